// File: rtl/gift_pkg.sv
// gift_pkg: shared nibble width, substitution FSM encoding and forward GIFT S-box table
package gift_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  // Entry for input 0 sits in the most significant nibble
  localparam logic [63:0] SBOX_FWD = 64'h1A4C6F392DB7508E;
  function automatic logic [NIBBLE_W-1:0] sbox_fwd(input logic [NIBBLE_W-1:0] x);
    return SBOX_FWD[{~x, 2'b00} +: NIBBLE_W];
  endfunction
endpackage

// File: rtl/gift_inv_sub_sched_sbox.sv
// GiftInvSboxFun: combinational GIFT inverse S-box for one nibble
module GiftInvSboxFun (
  input  logic [3:0] x,
  output logic [3:0] y
);
  localparam logic [63:0] SBOX_INV = 64'hD0862C4BE71A39F5;
  assign y = SBOX_INV[{~x, 2'b00} +: 4];
endmodule

// File: rtl/gift_inv_sub_sched.sv
// gift_inv_sub_sched: time-multiplexed GIFT inverse substitution, NUM_SBOX nibbles per cycle
// GIFT_SBOX_FWD_EN adds a modeFwd port selecting the forward S-box per job
module gift_inv_sub_sched
  import gift_pkg::*;
#(
  parameter int STATE_W  = 64,
  parameter int NUM_SBOX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inValid,
  output logic               inReady,
  input  logic [STATE_W-1:0] inData,
`ifdef GIFT_SBOX_FWD_EN
  input  logic               modeFwd,
`endif
  output logic               outValid,
  input  logic               outReady,
  output logic [STATE_W-1:0] outData,
  output logic               busy
);
  localparam int LW     = NUM_SBOX * NIBBLE_W;
  localparam int PASSES = STATE_W / LW;
  localparam int CNT_W  = PASSES > 1 ? $clog2(PASSES) : 1;
  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [STATE_W-1:0] state_reg;
  logic [LW-1:0]      lane_in, lane_out;
  logic               accept, last;
`ifdef GIFT_SBOX_FWD_EN
  logic               mode_reg;
`endif
  assign lane_in = state_reg[cnt*LW +: LW];
  assign last    = cnt == CNT_W'(PASSES - 1);
  assign accept  = inValid && inReady;
  assign outData = state_reg;
  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    logic [NIBBLE_W-1:0] inv;
    GiftInvSboxFun u_sbox (.x(lane_in[i*NIBBLE_W +: NIBBLE_W]), .y(inv));
`ifdef GIFT_SBOX_FWD_EN
    assign lane_out[i*NIBBLE_W +: NIBBLE_W] = mode_reg ? sbox_fwd(lane_in[i*NIBBLE_W +: NIBBLE_W]) : inv;
`else
    assign lane_out[i*NIBBLE_W +: NIBBLE_W] = inv;
`endif
  end
  always_comb begin
    state_nx = state;
    inReady  = state == IDLE || (state == DONE && outReady);
    outValid = state == DONE;
    busy     = state != IDLE;
    case (state)
      IDLE:    state_nx = inValid ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = outReady ? (inValid ? RUN : IDLE) : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      state_reg <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        state_reg <= inData;
        cnt       <= '0;
      end else if (state == RUN) begin
        state_reg[cnt*LW +: LW] <= lane_out;
        cnt <= last ? '0 : CNT_W'(cnt + 1'b1);
      end
    end
  end
`ifdef GIFT_SBOX_FWD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_reg <= 1'b0;
    else if (accept) mode_reg <= modeFwd;
  end
`endif
endmodule

// File: tb/tb_gift_inv_sub_sched.sv
// tb_gift_inv_sub_sched: directed checks of the GIFT substitution scheduler
// Three instances: 64/4 (main), 128/4 (wide) and 64/16 (single pass)
module tb_gift_inv_sub_sched;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;

  logic        a_iv = 0, a_ir, a_ov, a_or = 1, a_busy, a_mode = 0;
  logic [63:0] a_id = '0, a_od;
  logic         w_iv = 0, w_ir, w_ov, w_or = 1, w_busy, w_mode = 0;
  logic [127:0] w_id = '0, w_od;
  logic        s_iv = 0, s_ir, s_ov, s_or = 1, s_busy, s_mode = 0;
  logic [63:0] s_id = '0, s_od;

  gift_inv_sub_sched #(.STATE_W(64), .NUM_SBOX(4)) dut (
    .clk(clk), .rst(rst), .inValid(a_iv), .inReady(a_ir), .inData(a_id),
`ifdef GIFT_SBOX_FWD_EN
    .modeFwd(a_mode),
`endif
    .outValid(a_ov), .outReady(a_or), .outData(a_od), .busy(a_busy));
  gift_inv_sub_sched #(.STATE_W(128), .NUM_SBOX(4)) dut_w (
    .clk(clk), .rst(rst), .inValid(w_iv), .inReady(w_ir), .inData(w_id),
`ifdef GIFT_SBOX_FWD_EN
    .modeFwd(w_mode),
`endif
    .outValid(w_ov), .outReady(w_or), .outData(w_od), .busy(w_busy));
  gift_inv_sub_sched #(.STATE_W(64), .NUM_SBOX(16)) dut_s (
    .clk(clk), .rst(rst), .inValid(s_iv), .inReady(s_ir), .inData(s_id),
`ifdef GIFT_SBOX_FWD_EN
    .modeFwd(s_mode),
`endif
    .outValid(s_ov), .outReady(s_or), .outData(s_od), .busy(s_busy));

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accept one job on the main instance; returns edges from accept to outValid (0 on timeout)
  task automatic run_a(input logic [63:0] d, output int lat);
    a_iv = 1; a_id = d;
    step();
    a_iv = 0; a_id = 64'hDEAD_BEEF_DEAD_BEEF;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (a_ov) break;
      step();
      if (a_ov) lat = k;
    end
  endtask

  task automatic test_reset();
    rst = 1; #2;
    n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL reset_inReady got %b want 1", a_ir); end
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL reset_outValid got %b want 0", a_ov); end
    n_cmp++; if (a_od !== 64'h0) begin n_bad++; $display("FAIL reset_outData got %h want 0", a_od); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", a_busy); end
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic test_latency();
    int lat;
    a_or = 1; a_iv = 1; a_id = 64'h0123456789ABCDEF;
    step();
    a_iv = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!a_ov) begin
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy k=%0d got %b want 1", k, a_busy); end
      end
      step();
      if (a_ov) begin lat = k; break; end
    end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL lat_edges got %0d want 4", lat); end
    n_cmp++; if (a_od !== 64'hD0862C4BE71A39F5) begin n_bad++; $display("FAIL lat_data got %h want D0862C4BE71A39F5", a_od); end
    n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL lat_done_inReady got %b want 1", a_ir); end
    step();
    n_cmp++; if (a_ov !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL lat_idle ov=%b busy=%b want 0 0", a_ov, a_busy); end
  endtask

  task automatic test_backpressure();
    int lat;
    a_or = 0;
    run_a(64'h0123456789ABCDEF, lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL bp_lat got %0d want 4", lat); end
    a_iv = 1; a_id = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (a_ov !== 1'b1 || a_od !== 64'hD0862C4BE71A39F5 || a_ir !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold k=%0d ov=%b od=%h ir=%b want 1 D0862C4BE71A39F5 0", k, a_ov, a_od, a_ir);
      end
    end
    a_or = 1; #1;
    n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL bp_release_inReady got %b want 1", a_ir); end
    step();
    a_iv = 0;
    n_cmp++; if (a_ov !== 1'b0 || a_busy !== 1'b1) begin n_bad++; $display("FAIL bp_nobubble ov=%b busy=%b want 0 1", a_ov, a_busy); end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (a_ov) begin lat = k; break; end
    end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL bp_lat2 got %0d want 4", lat); end
    n_cmp++; if (a_od !== 64'h5555555555555555) begin n_bad++; $display("FAIL bp_data2 got %h want 5555555555555555", a_od); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a_or = 1; a_iv = 1; a_id = 64'h0123456789ABCDEF;
    step();
    a_iv = 0;
    step(); step();
    rst = 1; #1;
    n_cmp++;
    if (a_ov !== 1'b0 || a_od !== 64'h0 || a_ir !== 1'b1 || a_busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst ov=%b od=%h ir=%b busy=%b want 0 0 1 0", a_ov, a_od, a_ir, a_busy);
    end
    step();
    rst = 0;
    step();
    n_cmp++; if (a_ov !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_stay ov=%b busy=%b want 0 0", a_ov, a_busy); end
    run_a(64'h1111111111111111, lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL midrst_lat got %0d want 4", lat); end
    n_cmp++; if (a_od !== 64'h0) begin n_bad++; $display("FAIL midrst_data got %h want 0", a_od); end
    step();
  endtask

  task automatic test_wide();
    int lat = 0;
    w_or = 1; w_iv = 1; w_id = {2{64'h0123456789ABCDEF}};
    step();
    w_iv = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (w_ov) begin lat = k; break; end
    end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL wide_lat got %0d want 8", lat); end
    n_cmp++; if (w_od !== {2{64'hD0862C4BE71A39F5}}) begin n_bad++; $display("FAIL wide_data got %h want %h", w_od, {2{64'hD0862C4BE71A39F5}}); end
    step();
  endtask

  task automatic test_single_pass();
    int lat = 0;
    s_or = 1; s_iv = 1; s_id = 64'h0123456789ABCDEF;
    step();
    s_iv = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (s_ov) begin lat = k; break; end
    end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL single_lat got %0d want 1", lat); end
    n_cmp++; if (s_od !== 64'hD0862C4BE71A39F5) begin n_bad++; $display("FAIL single_data got %h want D0862C4BE71A39F5", s_od); end
    step();
  endtask

`ifdef GIFT_SBOX_FWD_EN
  task automatic test_forward();
    int lat;
    a_or = 1; a_mode = 1;
    run_a(64'h0, lat);
    n_cmp++; if (a_od !== 64'h1111111111111111) begin n_bad++; $display("FAIL fwd_zero got %h want 1111111111111111", a_od); end
    step();
    a_iv = 1; a_id = 64'hD0862C4BE71A39F5;
    step();
    a_iv = 0; a_mode = 0;
    step();
    a_mode = 1;
    step();
    a_mode = 0;
    for (int k = 0; k < 20 && !a_ov; k++) step();
    n_cmp++; if (a_od !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL fwd_inv got %h want 0123456789ABCDEF", a_od); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_reset_mid_run();
    test_wide();
    test_single_pass();
`ifdef GIFT_SBOX_FWD_EN
    test_forward();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
